// File: rtl/snn_noc_pkg.sv
// Shared constants and FSM encoding for the spike-to-NoC packet path.
// A packet carries the origin address in the upper half and the destination in the lower half.
package snn_noc_pkg;
  localparam int ADDR_W     = 12;
  localparam int PKT_W      = 2 * ADDR_W;
  localparam int ORIGIN_MSB = PKT_W - 1;
  localparam int ORIGIN_LSB = ADDR_W;
  localparam int DEST_MSB   = ADDR_W - 1;
  localparam int DEST_LSB   = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } sched_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above i_base, wrapping.
// Zero latency, no state; the caller owns the rotating base pointer.
module rr_arbiter #(
  parameter int N     = 10,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_base,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  function automatic int wrap_pos(input logic [IDX_W-1:0] base, input int off);
    int p;
    p = int'(base) + off;
    if (p >= N) p = p - N;
    return p;
  endfunction

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[wrap_pos(i_base, k)]) begin
        o_any                        = 1'b1;
        o_grant[wrap_pos(i_base, k)] = 1'b1;
        o_idx                        = IDX_W'(wrap_pos(i_base, k));
      end
    end
  end
endmodule

// File: rtl/spike_packet_scheduler.sv
// Captures spike edges, round-robins pending neurons and streams one packet per downstream link.
// First packet valid two cycles after the spike edge; packet/valid hold while pkt_ready is low.
module spike_packet_scheduler #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = snn_noc_pkg::ADDR_W,
  parameter int MAX_CONN    = 30,
  parameter int PTR_W       = 5
) (
  input  logic                             CLK,
  input  logic                             clear,
  input  logic                             cfg_load,
  input  logic [NUM_NEURONS*ADDR_W-1:0]    neuron_addresses_initialization,
  input  logic [(NUM_NEURONS+1)*PTR_W-1:0] connection_pointer_initialization,
  input  logic [MAX_CONN*ADDR_W-1:0]       downstream_connections_initialization,
  input  logic [NUM_NEURONS-1:0]           spike,
  input  logic                             pkt_ready,
  output logic                             pkt_valid,
  output logic [2*ADDR_W-1:0]              packet,
  output logic                             busy,
  output logic                             cfg_err,
  output logic [7:0]                       overrun_count
);
  import snn_noc_pkg::*;

  localparam int                IDX_W    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [PTR_W-1:0]  LIMIT    = PTR_W'(MAX_CONN);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  logic [ADDR_W-1:0] r_naddr   [NUM_NEURONS];
  logic [PTR_W-1:0]  r_ptr     [NUM_NEURONS+1];
  logic [ADDR_W-1:0] r_dstream [MAX_CONN];

  sched_state_e            r_state, w_state_nxt;
  logic [NUM_NEURONS-1:0]  r_pending, r_spike_prev;
  logic [IDX_W-1:0]        r_rr_ptr, r_g;
  logic [PTR_W-1:0]        r_cur, r_end;
  logic                    r_pkt_valid, r_cfg_err;
  logic [2*ADDR_W-1:0]     r_packet;
  logic [7:0]              r_overrun;

  logic [NUM_NEURONS-1:0]  w_grant, w_event, w_clr, w_lost;
  logic [IDX_W-1:0]        w_gidx;
  logic [IDX_W:0]          w_gidx_p1;
  logic                    w_any, w_bad, w_empty, w_last;
  logic [PTR_W-1:0]        w_ptr_lo, w_ptr_hi;
  logic                    w_grant_fire, w_start, w_step, w_done, w_set_err;
  logic [8:0]              w_lost_cnt, w_ovr_sum;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == LAST_IDX) ? '0 : v + IDX_W'(1);
  endfunction

  rr_arbiter #(.N(NUM_NEURONS), .IDX_W(IDX_W)) u_arb (
    .i_req   (r_pending),
    .i_base  (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_NEURONS; i++) r_naddr[i] <= '0;
      for (int i = 0; i <= NUM_NEURONS; i++) r_ptr[i] <= '0;
      for (int k = 0; k < MAX_CONN; k++) r_dstream[k] <= '0;
    end else if (cfg_load) begin
      for (int i = 0; i < NUM_NEURONS; i++)
        r_naddr[i] <= neuron_addresses_initialization[i*ADDR_W +: ADDR_W];
      for (int i = 0; i <= NUM_NEURONS; i++)
        r_ptr[i] <= connection_pointer_initialization[i*PTR_W +: PTR_W];
      for (int k = 0; k < MAX_CONN; k++)
        r_dstream[k] <= downstream_connections_initialization[k*ADDR_W +: ADDR_W];
    end
  end

  // A neuron's list is [ptr[g], ptr[g+1]); a list running backwards or past the table is a config fault.
  always_comb begin
    w_gidx_p1 = {1'b0, w_gidx} + (IDX_W+1)'(1);
    w_ptr_lo  = r_ptr[w_gidx];
    w_ptr_hi  = r_ptr[w_gidx_p1];
    w_bad     = (w_ptr_hi < w_ptr_lo) || (w_ptr_hi > LIMIT);
    w_empty   = (w_ptr_hi == w_ptr_lo);
    w_last    = ((r_cur + PTR_W'(1)) == r_end);
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (cfg_load) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_any && !w_bad && !w_empty) w_state_nxt = ST_SEND;
        ST_SEND: if (pkt_ready && w_last)         w_state_nxt = ST_IDLE;
        default:                                  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_grant_fire = 1'b0;
    w_start      = 1'b0;
    w_step       = 1'b0;
    w_done       = 1'b0;
    w_set_err    = 1'b0;
    if (!cfg_load) begin
      case (r_state)
        ST_IDLE: begin
          w_grant_fire = w_any;
          w_start      = w_any && !w_bad && !w_empty;
          w_set_err    = w_any && w_bad;
        end
        ST_SEND: begin
          w_step = pkt_ready && !w_last;
          w_done = pkt_ready && w_last;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      r_g         <= '0;
      r_cur       <= '0;
      r_end       <= '0;
      r_pkt_valid <= 1'b0;
      r_packet    <= '0;
      r_rr_ptr    <= '0;
      r_cfg_err   <= 1'b0;
    end else if (cfg_load) begin
      r_pkt_valid <= 1'b0;
      r_rr_ptr    <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      if (w_set_err) r_cfg_err <= 1'b1;
      if (w_grant_fire) begin
        r_g   <= w_gidx;
        r_cur <= w_ptr_lo;
        r_end <= w_ptr_hi;
        if (w_start) begin
          r_pkt_valid <= 1'b1;
          r_packet    <= {r_naddr[w_gidx], r_dstream[w_ptr_lo]};
        end else begin
          r_rr_ptr <= wrap_inc(w_gidx);
        end
      end
      if (w_step) begin
        r_cur    <= r_cur + PTR_W'(1);
        r_packet <= {r_naddr[r_g], r_dstream[r_cur + PTR_W'(1)]};
      end
      if (w_done) begin
        r_pkt_valid <= 1'b0;
        r_rr_ptr    <= wrap_inc(r_g);
      end
    end
  end

  // A fresh edge on a neuron being granted this cycle re-arms it rather than counting as lost.
  always_comb begin
    w_event    = spike & ~r_spike_prev;
    w_clr      = w_grant_fire ? w_grant : '0;
    w_lost     = w_event & r_pending & ~w_clr;
    w_lost_cnt = '0;
    for (int i = 0; i < NUM_NEURONS; i++) w_lost_cnt = w_lost_cnt + 9'(w_lost[i]);
    w_ovr_sum  = {1'b0, r_overrun} + w_lost_cnt;
  end

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      r_pending    <= '0;
      r_spike_prev <= '0;
      r_overrun    <= '0;
    end else begin
      r_spike_prev <= spike;
      if (cfg_load) begin
        r_pending <= '0;
      end else begin
        r_pending <= (r_pending & ~w_clr) | w_event;
        r_overrun <= w_ovr_sum[8] ? 8'hFF : w_ovr_sum[7:0];
      end
    end
  end

  assign pkt_valid     = r_pkt_valid;
  assign packet        = r_packet;
  assign busy          = (r_state != ST_IDLE) || (|r_pending);
  assign cfg_err       = r_cfg_err;
  assign overrun_count = r_overrun;
endmodule

// File: tb/tb_spike_packet_scheduler.sv
// Directed scenarios plus randomized spike rounds scored against a list-level model of the scheduler.
module tb_spike_packet_scheduler;
  import snn_noc_pkg::*;

  localparam int N  = 10;
  localparam int AW = ADDR_W;
  localparam int MC = 30;
  localparam int PW = 5;

  logic                CLK = 1'b0;
  logic                clear, cfg_load, pkt_ready, pkt_valid, busy, cfg_err;
  logic [N*AW-1:0]     naddr_bus;
  logic [(N+1)*PW-1:0] ptr_bus;
  logic [MC*AW-1:0]    dst_bus;
  logic [N-1:0]        spike;
  logic [PKT_W-1:0]    packet;
  logic [7:0]          overrun_count;

  int checks   = 0;
  int failures = 0;
  int m_naddr [N];
  int m_ptr   [N+1];
  int m_dst   [MC];
  int rr_m;
  logic [PKT_W-1:0] mon_q [$];
  logic [PKT_W-1:0] exp_q [$];

  always #5 CLK = ~CLK;

  spike_packet_scheduler dut (
    .CLK                                   (CLK),
    .clear                                 (clear),
    .cfg_load                              (cfg_load),
    .neuron_addresses_initialization       (naddr_bus),
    .connection_pointer_initialization     (ptr_bus),
    .downstream_connections_initialization (dst_bus),
    .spike                                 (spike),
    .pkt_ready                             (pkt_ready),
    .pkt_valid                             (pkt_valid),
    .packet                                (packet),
    .busy                                  (busy),
    .cfg_err                               (cfg_err),
    .overrun_count                         (overrun_count)
  );

  // Inputs change 1ns after the rising edge, so the value seen here is the one the next edge uses.
  always @(negedge CLK) if (!clear && pkt_valid && pkt_ready) mon_q.push_back(packet);

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_cfg();
    for (int i = 0; i < N; i++)  naddr_bus[i*AW +: AW] = AW'(m_naddr[i]);
    for (int i = 0; i <= N; i++) ptr_bus[i*PW +: PW]   = PW'(m_ptr[i]);
    for (int k = 0; k < MC; k++) dst_bus[k*AW +: AW]   = AW'(m_dst[k]);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    rr_m = 0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    spike = m;
    tick();
    spike = '0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd_ready, input string tag);
    for (int c = 0; c < budget && busy; c++) begin
      if (rnd_ready) pkt_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk(tag, busy, 0);
  endtask

  task automatic cmp_stream(input int base, input string tag);
    chk({tag, "_count"}, 32'(mon_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < mon_q.size()) chk(tag, mon_q[base + i], exp_q[i]);
  endtask

  task automatic cfg_a();
    for (int i = 0; i < N; i++)  m_naddr[i] = i + 1;
    for (int k = 0; k < MC; k++) m_dst[k] = 0;
    m_dst[0] = 'h101; m_dst[1] = 'h102; m_dst[2] = 'h103; m_dst[3] = 'h201; m_dst[4] = 'h202;
    m_ptr[0] = 0; m_ptr[1] = 3; m_ptr[2] = 3;
    for (int i = 3; i <= N; i++) m_ptr[i] = 5;
  endtask

  initial begin
    int base, last, n;
    logic [N-1:0] m;

    clear = 1'b1; cfg_load = 1'b0; spike = '0; pkt_ready = 1'b0;
    naddr_bus = '0; ptr_bus = '0; dst_bus = '0; rr_m = 0;
    tick(); tick();
    chk("rst_valid", pkt_valid, 0);
    chk("rst_packet", packet, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_overrun", overrun_count, 0);
    clear = 1'b0;
    tick();

    // Basic three-entry list on neuron 0.
    cfg_a(); load_cfg();
    chk("cfg_err_after_load", cfg_err, 0);
    pkt_ready = 1'b1;
    pulse(10'h001);
    chk("t1_busy_at_edge", busy, 1);
    chk("t1_valid_at_edge", pkt_valid, 0);
    tick(); chk("t1_pkt0", {pkt_valid, packet}, {1'b1, 24'h001101});
    tick(); chk("t1_pkt1", {pkt_valid, packet}, {1'b1, 24'h001102});
    tick(); chk("t1_pkt2", {pkt_valid, packet}, {1'b1, 24'h001103});
    tick(); chk("t1_valid_end", pkt_valid, 0);
    chk("t1_busy_end", busy, 0);

    // Empty list on neuron 1, then rr should start at neuron 2.
    pulse(10'h002);
    chk("t2_busy_at_edge", busy, 1);
    tick();
    chk("t2_busy_after", busy, 0);
    chk("t2_no_valid", pkt_valid, 0);
    base = mon_q.size();
    pulse(10'h005);
    wait_idle(50, 0, "t2b_idle");
    exp_q = '{24'h003201, 24'h003202, 24'h001101, 24'h001102, 24'h001103};
    cmp_stream(base, "t2b_order");

    // Back-pressure mid-list.
    pulse(10'h001);
    tick(); chk("t4_pkt0", {pkt_valid, packet}, {1'b1, 24'h001101});
    tick(); chk("t4_pkt1", {pkt_valid, packet}, {1'b1, 24'h001102});
    pkt_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(); chk("t4_hold", {pkt_valid, packet}, {1'b1, 24'h001102});
    end
    pkt_ready = 1'b1;
    tick(); chk("t4_resume", {pkt_valid, packet}, {1'b1, 24'h001103});
    tick(); chk("t4_valid_end", pkt_valid, 0);

    // Neuron 0 re-spikes exactly on the edge that grants it: re-armed, not counted.
    base = mon_q.size();
    spike = 10'h004; tick();
    spike = 10'h001; tick();
    spike = 10'h000; tick();
    tick();
    spike = 10'h001; tick();
    spike = 10'h000;
    chk("t5b_no_overrun", overrun_count, 0);
    wait_idle(60, 0, "t5b_idle");
    exp_q = '{24'h003201, 24'h003202, 24'h001101, 24'h001102, 24'h001103,
              24'h001101, 24'h001102, 24'h001103};
    cmp_stream(base, "t5b_stream");

    // Overruns while neuron 0 stays pending behind a stalled list.
    pkt_ready = 1'b0;
    spike = 10'h001; tick(); tick();
    for (int e = 0; e < 3; e++) begin
      spike = 10'h000; tick();
      spike = 10'h001; tick();
    end
    chk("t5_overrun_2", overrun_count, 2);
    for (int e = 0; e < 298; e++) begin
      spike = 10'h000; tick();
      spike = 10'h001; tick();
    end
    chk("t5_overrun_sat", overrun_count, 255);
    spike = '0; pkt_ready = 1'b1;
    wait_idle(100, 0, "t5_idle");

    // Round-robin from rr=4 with neurons 0, 3, 7 together.
    for (int i = 0; i < N; i++)  m_naddr[i] = 'h100 + i;
    for (int k = 0; k < MC; k++) m_dst[k] = 'hA00 + k;
    for (int i = 0; i <= N; i++) m_ptr[i] = i;
    load_cfg();
    pulse(10'h008);
    wait_idle(20, 0, "t3_idle_a");
    base = mon_q.size();
    pulse(10'h089);
    wait_idle(40, 0, "t3_idle_b");
    exp_q = '{24'h107A07, 24'h100A00, 24'h103A03};
    cmp_stream(base, "t3_order");

    // Inconsistent pointer tables.
    m_ptr = '{0, 0, 0, 0, 0, 7, 4, 4, 31, 31, 31};
    load_cfg();
    chk("t6_err_clear", cfg_err, 0);
    pulse(10'h020);
    tick();
    chk("t6_err_backwards", cfg_err, 1);
    chk("t6_no_valid", pkt_valid, 0);
    chk("t6_busy", busy, 0);
    load_cfg();
    chk("t6_err_reload", cfg_err, 0);
    pulse(10'h080);
    tick();
    chk("t6_err_beyond", cfg_err, 1);
    chk("t6_no_valid_b", pkt_valid, 0);

    // Randomized rounds against a list-level model.
    for (int i = 0; i < N; i++) m_naddr[i] = int'($urandom_range(0, 4095));
    for (int k = 0; k < MC; k++) m_dst[k] = int'($urandom_range(0, 4095));
    m_ptr[0] = 0;
    for (int i = 0; i < N; i++) m_ptr[i+1] = m_ptr[i] + int'($urandom_range(0, 3));
    load_cfg();
    for (int r = 0; r < 25; r++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      exp_q.delete();
      last = rr_m;
      for (int o = 0; o < N; o++) begin
        n = (rr_m + o) % N;
        if (m[n]) begin
          for (int k = m_ptr[n]; k < m_ptr[n+1]; k++)
            exp_q.push_back({AW'(m_naddr[n]), AW'(m_dst[k])});
          last = n;
        end
      end
      rr_m = (last + 1) % N;
      base = mon_q.size();
      pulse(m);
      wait_idle(400, 1, "rnd_idle");
      cmp_stream(base, "rnd_stream");
    end
    chk("rnd_cfg_err", cfg_err, 0);

    // Asynchronous clear in the middle of a list.
    pkt_ready = 1'b1;
    cfg_a(); load_cfg();
    pkt_ready = 1'b0;
    pulse(10'h001);
    tick();
    chk("t7_valid_pre", pkt_valid, 1);
    #2 clear = 1'b1;
    #1;
    chk("t7_valid", pkt_valid, 0);
    chk("t7_packet", packet, 0);
    chk("t7_busy", busy, 0);
    chk("t7_overrun", overrun_count, 0);
    chk("t7_cfg_err", cfg_err, 0);
    tick(); tick();
    clear = 1'b0;
    pkt_ready = 1'b1;
    pulse(10'h001);
    tick();
    chk("t7_tables_zero", pkt_valid, 0);
    chk("t7_busy_after", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
